fp_mult_stream: RTL and testbench
=================================

# fp_mult_stream

Streaming front end for the combinational 32-bit IEEE-754 `Multiplication` block. It accepts operand pairs over a valid/ready handshake, buffers them in a small FIFO, and drives the head pair onto the multiplier's `a_operand`/`b_operand`. It registers the multiplier's `result`/`Exception`/`Overflow`/`Underflow` into an output stage with its own valid/ready handshake. It sits between the operand source (test-vector player or ALU issue logic) and the result consumer, and turns the bare combinational multiplier into a back-pressurable pipeline stage.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept a pair; equals `count != DEPTH`.
- `in_a` in 32: operand A.
- `in_b` in 32: operand B.
- `mul_a` out 32: to multiplier `a_operand`; FIFO head, 0 when FIFO empty.
- `mul_b` out 32: to multiplier `b_operand`; FIFO head, 0 when FIFO empty.
- `mul_result` in 32: from multiplier `result`.
- `mul_flags` in 3: {Exception, Overflow, Underflow} from multiplier.
- `out_valid` out 1: output register holds a result.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: registered product.
- `out_flags` out 3: registered {Exception, Overflow, Underflow}.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `clear_flags` in 1: clears sticky flags (macro-dependent).
- `sticky_flags` out 3: accumulated flags (macro-dependent).

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {in_a,in_b} at wr_ptr. wr_ptr increments modulo DEPTH.
- Pop: `count != 0 && (!out_valid || out_ready)`. On pop:
  - rd_ptr increments modulo DEPTH.
  - `out_result <= mul_result`, `out_flags <= mul_flags`, `out_valid <= 1`.
- If there is no pop and `out_valid && out_ready`, `out_valid <= 0`. `out_result`/`out_flags` hold their last value.
- Push and pop in the same cycle: count unchanged. Push only: +1. Pop only: −1.
- Full (count == DEPTH): `in_ready` = 0, so no push. A pop in that cycle frees a slot from the next cycle only; there is no combinational ready bypass.
- Empty: `mul_a`/`mul_b` = 0. No pop. No write-through bypass, so a push into an empty FIFO is not visible until the next edge.
- Total buffering is DEPTH + 1: FIFO plus the output register.
- Output holding rule: with `out_valid` = 1 and `out_ready` = 0, all outputs hold stable.
- Order is strictly FIFO; results leave in push order.
- Reset values:
  - `in_ready` = 1, `count` = 0, pointers 0.
  - `out_valid` = 0, `out_result` = 0, `out_flags` = 0, `sticky_flags` = 0.
  - `mul_a`/`mul_b` = 0.
- Reset mid-operation discards all buffered pairs and any pending result immediately (asynchronously).

## Timing
- Latency: a pair pushed at edge N into an empty pipe is popped at edge N+1. `out_valid` is high after edge N+1.
- Throughput: 1 result per cycle when `out_ready` is held high.
- `mul_*` is a purely combinational path through the multiplier and must close within one `clk` period.
- `in_ready`, `count`, `mul_a` and `mul_b` are functions of registered state only.

## Configuration
- `FP_MULT_STICKY_FLAGS_EN` defined:
  - On every pop, `sticky_flags <= sticky_flags | mul_flags`.
  - `clear_flags` = 1 at an edge sets `sticky_flags <= mul_flags` if popping that edge, else 0. The clear and the new capture resolve so that the captured flags survive.
- `FP_MULT_STICKY_FLAGS_EN` undefined: `sticky_flags` is tied to 0 and `clear_flags` is ignored.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `out_valid` = 0, `count` = 0, `in_ready` = 1, `out_result` = 0 before the next edge.
- Single op: push 3f800000 × 40000000 at edge N → `out_valid` = 1 after edge N+1, with `out_result` = 40000000 and `out_flags` = 000.
- Back-pressure: `out_ready` = 0, push 5 pairs (DEPTH = 4) → after the 5th push `count` = 4 and `in_ready` = 0. Then raise `out_ready` → 5 results in push order, one per cycle.
- Streaming: `out_ready` = 1, push every cycle for 100 cycles → `count` ≤ 1 and `in_ready` always 1. Output sequence matches the Python-generated vectors.
- Flags: push 7f000000 × 7f000000 → `out_flags[1]` (Overflow) = 1. With `FP_MULT_STICKY_FLAGS_EN`, `sticky_flags[1]` stays 1 through later clean results until `clear_flags`.
- Reset with 3 pairs buffered and `out_valid` = 1 → all discarded. The first push after release yields only its own result.

Source files
------------

// File: rtl/fp_mult_stream.sv
// fp_mult_stream: valid/ready streaming wrapper around the combinational
// IEEE-754 single-precision multiplier. Operand pairs queue in a DEPTH-entry
// FIFO whose head drives the multiplier; products land in a registered output
// stage with its own handshake.
// Optional feature macro: FP_MULT_STICKY_FLAGS_EN (accumulated flags with clear).
module fp_mult_stream #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  input  logic [31:0]   mul_result,
  input  logic [2:0]    mul_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [2:0]    out_flags,
  output logic [AW:0]   count,
  input  logic          clear_flags,
  output logic [2:0]    sticky_flags
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  pair_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           out_valid_q, out_valid_d;
  logic [31:0]    out_result_q, out_result_d;
  logic [2:0]     out_flags_q, out_flags_d;

  logic push, pop;
  pair_t head;

  // Handshake decode; ready and head depend on registered state only.
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);
  assign head     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign mul_a    = head.a;
  assign mul_b    = head.b;

  assign count      = count_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  // Pointer, occupancy and output-stage next state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      out_valid_d  = 1'b1;
      out_result_d = mul_result;
      out_flags_d  = mul_flags;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand storage; only the slot at wr_ptr changes on a push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, b: in_b};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

`ifdef FP_MULT_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  // Clear wins over history but never over the flags captured this edge.
  always_comb begin
    sticky_d = sticky_q;
    if (pop)              sticky_d = clear_flags ? mul_flags : (sticky_q | mul_flags);
    else if (clear_flags) sticky_d = '0;
  end

  // Sticky flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clear;
  assign unused_clear = clear_flags;
  assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fp_mult_stream.sv
// Bench for fp_mult_stream: stands in for the multiplier with a behavioural
// float product and scoreboards results against pushed pairs in push order.
module tb_fp_mult_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [2:0]  mul_flags;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [2:0]  count;
  logic        clear_flags = 1'b0;
  logic [2:0]  sticky_flags;

  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];

  fp_mult_stream #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_flags(mul_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count), .clear_flags(clear_flags), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply; returns {exc, ovf, unf, result}.
  function automatic logic [34:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    logic        s, ex, ov, un;
    logic [31:0] r;
    s  = a[31] ^ b[31];
    ex = (a[30:23] == 8'hff) || (b[30:23] == 8'hff);
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    ov = !ex && (e >= 255);
    un = !ex && (e <= 0);
    if (ex)      r = {s, 8'hff, 23'h400000};
    else if (ov) r = {s, 8'hff, 23'd0};
    else if (un) r = {s, 31'd0};
    else         r = {s, e[7:0], m};
    return {ex, ov, un, r};
  endfunction

  assign {mul_flags, mul_result} = fpmul(mul_a, mul_b);

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, book the handshakes, cross the edge, check.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy, input logic clr);
    logic        hold;
    logic [35:0] held;
    in_valid = v; in_a = a; in_b = b; out_ready = rdy; clear_flags = clr;
    #1;
    hold = out_valid && !out_ready;
    held = {out_valid, out_flags, out_result};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 36'(out_valid), 36'd0);
      else begin
        check("result", {1'b0, out_flags, out_result}, {1'b0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) exp_q.push_back(fpmul(in_a, in_b));
    @(negedge clk);
    check("occupancy", 36'(count) + 36'(out_valid), 36'(exp_q.size()));
    check("in_ready", 36'(in_ready), 36'(count != 3'd4));
    if (hold) check("hold", {out_valid, out_flags, out_result}, held);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  logic [31:0] ra, rb;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 36'(out_valid), 36'd0);
    check("rst_count", 36'(count), 36'd0);
    check("rst_ready", 36'(in_ready), 36'd1);
    check("rst_result", {out_flags, out_result}, 36'd0);
    check("rst_mul", {4'd0, mul_a}, 36'd0);
    check("rst_sticky", 36'(sticky_flags), 36'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single op latency: pushed at edge N, visible after edge N+1
    step(1'b1, 32'h3f800000, 32'h40000000, 1'b1, 1'b0);
    check("lat_n_valid", 36'(out_valid), 36'd0);
    check("lat_n_mul_a", {4'd0, mul_a}, 36'h03f800000);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("lat_n1_valid", 36'(out_valid), 36'd1);
    check("lat_n1_result", {1'b0, out_flags, out_result}, 36'h040000000);
    check("empty_mul_b", {4'd0, mul_b}, 36'd0);
    idle(1'b1);

    // Back-pressure: 5 pairs held, FIFO full, then drain in order
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h3f800000 + 32'(i << 20), 32'h40400000, 1'b0, 1'b0);
    check("bp_full_count", 36'(count), 36'd4);
    check("bp_full_ready", 36'(in_ready), 36'd0);
    step(1'b1, 32'h12345678, 32'h3f800000, 1'b0, 1'b0);   // refused while full
    for (int i = 0; i < 6; i++) idle(1'b1);
    check("bp_drained", 36'(exp_q.size()), 36'd0);

    // Streaming at full rate
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 10 != 0) begin
        ra[30:23] = 8'($urandom_range(160, 95));
        rb[30:23] = 8'($urandom_range(160, 95));
      end
      step(1'b1, ra, rb, 1'b1, 1'b0);
      check("stream_count", 36'(count <= 3'd1), 36'd1);
      check("stream_ready", 36'(in_ready), 36'd1);
    end
    idle(1'b1); idle(1'b1);

    // Random back-pressure with gaps
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom;
      ra[30:23] = 8'($urandom_range(150, 100));
      step(1'($urandom_range(1, 0)), ra, rb, 1'($urandom_range(1, 0)), 1'b0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Overflow flag, then a clean result
    step(1'b1, 32'h7f000000, 32'h7f000000, 1'b1, 1'b0);
    step(1'b1, 32'h3f800000, 32'h3f800000, 1'b1, 1'b0);
    check("ovf_flag", 36'(out_flags), 36'b010);
    idle(1'b1);
    check("clean_flag", 36'(out_flags), 36'd0);
    idle(1'b1);
`ifdef FP_MULT_STICKY_FLAGS_EN
    check("sticky_hold", 36'(sticky_flags[1]), 36'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("sticky_clear", 36'(sticky_flags), 36'd0);
`else
    check("sticky_tied", 36'(sticky_flags), 36'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("sticky_tied_clr", 36'(sticky_flags), 36'd0);
`endif

    // Asynchronous reset with 3 pairs buffered and a result pending
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h40000000 + 32'(i << 21), 32'h40000000, 1'b0, 1'b0);
    check("pre_rst_count", 36'(count), 36'd3);
    check("pre_rst_valid", 36'(out_valid), 36'd1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 36'(out_valid), 36'd0);
    check("arst_count", 36'(count), 36'd0);
    check("arst_ready", 36'(in_ready), 36'd1);
    check("arst_result", {out_flags, out_result}, 36'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'h40400000, 32'h40000000, 1'b1, 1'b0);
    idle(1'b1);
    check("post_rst_result", {1'b0, out_flags, out_result}, 36'h040c00000);
    idle(1'b1);
    idle(1'b1);
    check("post_rst_empty", 36'(out_valid), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
